// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter.
// Address/word widths, FSM state and owner encodings.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner select for the memory port arbiter.
// Lock state wins; in IDLE D beats I unless I is starved.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  arb_state_e state,
  input  logic       i_valid,
  input  logic       d_valid,
  input  logic       starve_flag,
  output owner_e     owner
);

  always_comb begin
    owner = OWN_NONE;
    unique case (1'b1)
      state == ST_LOCK_I: owner = OWN_I;
      state == ST_LOCK_D: owner = OWN_D;
      default: begin
        if (d_valid && !(i_valid && starve_flag))
          owner = OWN_D;
        else if (i_valid)
          owner = OWN_I;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// I/D arbiter onto one single-ported memory, valid/ready, 0-cycle pass-through.
// `MEM_ARB_PERF_EN adds perf_i_stall_o / perf_d_stall_o stall-cycle counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_valid_i,
  output logic              imem_ready_o,
  input  logic [ADDR_W-1:0] imem_addr_i,
  input  logic [WORD_W-1:0] imem_wdata_i,
  input  logic [3:0]        imem_we_i,
  output logic [WORD_W-1:0] imem_rdata_o,
  input  logic              dmem_valid_i,
  output logic              dmem_ready_o,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic [WORD_W-1:0] dmem_wdata_i,
  input  logic [3:0]        dmem_we_i,
  output logic [WORD_W-1:0] dmem_rdata_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_we_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              grant_d_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_stall_o,
  output logic [31:0]       perf_d_stall_o
`endif
);

  localparam logic [CNT_WIDTH-1:0] LIM =
    CNT_WIDTH'(STARVE_LIMIT);

  arb_state_e           state_q;
  arb_state_e           state_d;
  owner_e               owner;
  logic [CNT_WIDTH-1:0] starve_cnt;
  logic                 starve_flag;
  logic                 own_valid;

  assign starve_flag = (STARVE_LIMIT != 0) &&
                       (starve_cnt == LIM);

  mem_arb_pick u_pick (
    .state       (state_q),
    .i_valid     (imem_valid_i),
    .d_valid     (dmem_valid_i),
    .starve_flag (starve_flag),
    .owner       (owner)
  );

  always_comb begin
    own_valid   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = '0;
    unique case (1'b1)
      owner == OWN_I: begin
        own_valid   = imem_valid_i;
        mem_addr_o  = imem_addr_i;
        mem_wdata_o = imem_wdata_i;
        mem_we_o    = imem_we_i;
      end
      owner == OWN_D: begin
        own_valid   = dmem_valid_i;
        mem_addr_o  = dmem_addr_i;
        mem_wdata_o = dmem_wdata_i;
        mem_we_o    = dmem_we_i;
      end
      default: ;
    endcase
  end

  assign mem_valid_o  = own_valid & rst_n;
  assign grant_d_o    = (owner == OWN_D);
  assign imem_ready_o = mem_ready_i & imem_valid_i &
                        (owner == OWN_I);
  assign dmem_ready_o = mem_ready_i & dmem_valid_i &
                        (owner == OWN_D);
  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;

  always_comb begin
    state_d = ST_IDLE;
    if (own_valid && !mem_ready_i)
      state_d = (owner == OWN_D) ? ST_LOCK_D
                                 : ST_LOCK_I;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (dmem_ready_o && imem_valid_i) begin
      if (starve_cnt != LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end else if (imem_ready_o || !imem_valid_i)
      starve_cnt <= '0;
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_stall_o <= '0;
      perf_d_stall_o <= '0;
    end else begin
      if (imem_valid_i && owner != OWN_I)
        perf_i_stall_o <= perf_i_stall_o + 32'd1;
      if (dmem_valid_i && owner != OWN_D)
        perf_d_stall_o <= perf_d_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter.
// Per-cycle vectors plus a reset-during-lock sequence.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_valid_i = 1'b0;
  logic        imem_ready_o;
  logic [31:0] imem_addr_i = '0;
  logic [31:0] imem_wdata_i = '0;
  logic [3:0]  imem_we_i = '0;
  logic [31:0] imem_rdata_o;
  logic        dmem_valid_i = 1'b0;
  logic        dmem_ready_o;
  logic [31:0] dmem_addr_i = '0;
  logic [31:0] dmem_wdata_i = 32'hdead_beef;
  logic [3:0]  dmem_we_i = '0;
  logic [31:0] dmem_rdata_o;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_rdata_i = '0;
  logic        grant_d_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_stall_o;
  logic [31:0] perf_d_stall_o;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_valid_i (imem_valid_i),
    .imem_ready_o (imem_ready_o),
    .imem_addr_i  (imem_addr_i),
    .imem_wdata_i (imem_wdata_i),
    .imem_we_i    (imem_we_i),
    .imem_rdata_o (imem_rdata_o),
    .dmem_valid_i (dmem_valid_i),
    .dmem_ready_o (dmem_ready_o),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_we_i    (dmem_we_i),
    .dmem_rdata_o (dmem_rdata_o),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_we_o     (mem_we_o),
    .mem_rdata_i  (mem_rdata_i),
    .grant_d_o    (grant_d_o)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_i_stall_o (perf_i_stall_o),
    .perf_d_stall_o (perf_d_stall_o)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [3:0]  dwe;
    logic        rdy;
    logic        e_mv;
    logic [31:0] e_ma;
    logic [3:0]  e_we;
    logic        e_ir;
    logic        e_dr;
    logic        e_gd;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    logic iv, logic [31:0] ia,
    logic dv, logic [31:0] da,
    logic [3:0] dwe, logic rdy,
    logic e_mv, logic [31:0] e_ma,
    logic [3:0] e_we, logic e_ir,
    logic e_dr, logic e_gd);
    vec_t v;
    v.iv = iv; v.ia = ia;
    v.dv = dv; v.da = da;
    v.dwe = dwe; v.rdy = rdy;
    v.e_mv = e_mv; v.e_ma = e_ma;
    v.e_we = e_we; v.e_ir = e_ir;
    v.e_dr = e_dr; v.e_gd = e_gd;
    return v;
  endfunction

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // Drive just after posedge, check at negedge.
  task automatic apply(vec_t v, int idx);
    logic [31:0] rd;
    rd = $urandom;
    imem_valid_i = v.iv;
    imem_addr_i  = v.ia;
    dmem_valid_i = v.dv;
    dmem_addr_i  = v.da;
    dmem_we_i    = v.dwe;
    mem_ready_i  = v.rdy;
    mem_rdata_i  = rd;
    @(negedge clk);
    chk($sformatf("v%0d mem_valid", idx),
        32'(mem_valid_o), 32'(v.e_mv));
    chk($sformatf("v%0d mem_addr", idx),
        mem_addr_o, v.e_ma);
    chk($sformatf("v%0d mem_we", idx),
        32'(mem_we_o), 32'(v.e_we));
    chk($sformatf("v%0d imem_ready", idx),
        32'(imem_ready_o), 32'(v.e_ir));
    chk($sformatf("v%0d dmem_ready", idx),
        32'(dmem_ready_o), 32'(v.e_dr));
    chk($sformatf("v%0d grant_d", idx),
        32'(grant_d_o), 32'(v.e_gd));
    if (v.e_ir)
      chk($sformatf("v%0d irdata", idx),
          imem_rdata_o, rd);
    if (v.e_dr)
      chk($sformatf("v%0d drdata", idx),
          dmem_rdata_o, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic starve_run(int base);
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4)
        apply(mk(1, 32'h200, 1, 32'h3000,
                 4'hF, 1, 1, 32'h200, 4'h0,
                 1, 0, 0), base + k);
      else
        apply(mk(1, 32'h200, 1, 32'h3000,
                 4'hF, 1, 1, 32'h3000, 4'hF,
                 0, 1, 1), base + k);
    end
  endtask

  initial begin
    // I alone, zero latency
    tv.push_back(mk(1, 32'h100, 0, 32'h0,
      4'h0, 1, 1, 32'h100, 4'h0, 1, 0, 0));
    // contention: D first, then I
    tv.push_back(mk(1, 32'h104, 1, 32'h2000,
      4'hF, 1, 1, 32'h2000, 4'hF, 0, 1, 1));
    tv.push_back(mk(1, 32'h104, 0, 32'h0,
      4'h0, 1, 1, 32'h104, 4'h0, 1, 0, 0));
    // I locks; D arrives; addr redirect
    tv.push_back(mk(1, 32'h108, 0, 32'h0,
      4'h0, 0, 1, 32'h108, 4'h0, 0, 0, 0));
    tv.push_back(mk(1, 32'h10C, 1, 32'h2004,
      4'h3, 0, 1, 32'h10C, 4'h0, 0, 0, 0));
    tv.push_back(mk(1, 32'h10C, 1, 32'h2004,
      4'h3, 1, 1, 32'h10C, 4'h0, 1, 0, 0));
    tv.push_back(mk(0, 32'h0, 1, 32'h2004,
      4'h3, 1, 1, 32'h2004, 4'h3, 0, 1, 1));
    // I locks then withdraws; D next
    tv.push_back(mk(1, 32'h300, 0, 32'h0,
      4'h0, 0, 1, 32'h300, 4'h0, 0, 0, 0));
    tv.push_back(mk(0, 32'h300, 1, 32'h4000,
      4'h1, 1, 0, 32'h300, 4'h0, 0, 0, 0));
    tv.push_back(mk(0, 32'h300, 1, 32'h4000,
      4'h1, 1, 1, 32'h4000, 4'h1, 0, 1, 1));
    // idle
    tv.push_back(mk(0, 32'h0, 0, 32'h0,
      4'h0, 1, 0, 32'h0, 4'h0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst mem_valid", 32'(mem_valid_o), 0);
    chk("rst grant_d", 32'(grant_d_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tv[i]) apply(tv[i], i);
    starve_run(100);

    // build starve_cnt=2, then lock D
    apply(mk(1, 32'h500, 1, 32'h5000, 4'h2, 1,
             1, 32'h5000, 4'h2, 0, 1, 1), 200);
    apply(mk(1, 32'h500, 1, 32'h5000, 4'h2, 1,
             1, 32'h5000, 4'h2, 0, 1, 1), 201);
    apply(mk(1, 32'h500, 1, 32'h6000, 4'h4, 0,
             1, 32'h6000, 4'h4, 0, 0, 1), 202);
    chk("lockd grant_d", 32'(grant_d_o), 1);
    chk("lockd mem_valid", 32'(mem_valid_o), 1);
    rst_n = 1'b0;
    #1;
    chk("rst mid mem_valid", 32'(mem_valid_o), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MEM_ARB_PERF_EN
    chk("perf_i after rst", perf_i_stall_o, 0);
    chk("perf_d after rst", perf_d_stall_o, 0);
`endif
    @(posedge clk);
    #1;
    // cleared counter: full D,D,D,D,I again
    starve_run(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
